// File: rtl/sdram_pkg.sv
// -----------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the SDRAM controller front end and its sub-engines.
//   sel_e      : command-bus mux select codes (INIT/REF/WR/RD)
//   state_e    : front-end FSM state codes
//   owed_next  : saturating up/down update of the owed-refresh counter
// No ports (package).
// -----------------------------------------------------------------------------
package sdram_pkg;

    typedef enum logic [1:0] {
        SEL_INIT = 2'd0,
        SEL_REF  = 2'd1,
        SEL_WR   = 2'd2,
        SEL_RD   = 2'd3
    } sel_e;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_REF  = 3'd2,
        ST_WR   = 3'd3,
        ST_RD   = 3'd4
    } state_e;

    localparam logic [1:0] REF_OWED_MAX = 2'd3;

    // A wrap and a completed refresh in the same cycle cancel out; otherwise
    // count up (saturating, so a late refresh is never forgotten) or down.
    function automatic logic [1:0] owed_next(input logic [1:0] owed,
                                             input logic       inc,
                                             input logic       dec);
        logic [1:0] r;
        r = owed;
        if (inc && !dec) begin
            if (owed != REF_OWED_MAX) r = owed + 2'd1;
        end else if (dec && !inc) begin
            if (owed != 2'd0) r = owed - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sdram_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_rr_arbiter
// Combinational one-hot round-robin grant. The search begins at the channel
// after last_i and wraps from NUM_CH-1 back to 0.
//   req_i        in  NUM_CH : request vector
//   last_i       in  PTR_W  : index of the last channel served
//   grant_o      out NUM_CH : one-hot winner (zero when no request)
//   grant_idx_o  out PTR_W  : binary index of the winner
//   valid_o      out 1      : at least one request present
// -----------------------------------------------------------------------------
module sdram_rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [PTR_W-1:0]  last_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [PTR_W-1:0]  grant_idx_o,
    output logic              valid_o
);

    always_comb begin
        int idx;
        idx         = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        // Offset 1..NUM_CH visits every channel once, last_i itself last.
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(last_i) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!valid_o && req_i[idx[PTR_W-1:0]]) begin
                valid_o                   = 1'b1;
                grant_o[idx[PTR_W-1:0]]   = 1'b1;
                grant_idx_o               = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sdram_mc_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_mc_arbiter
// Multi-channel front end: round-robin arbitration of NUM_CH local ports,
// auto-refresh interval counting and sequencing of init/refresh/write/read
// engines over a shared command bus.
//   clk, rst_n                       : clock, async active-low reset
//   init_done/ref_done/wr_done/rd_done in : engine completion
//   init_en out (level), ref_en/wr_en/rd_en out (one-cycle start pulses)
//   sel out [1:0]                    : command-bus mux select (sel_e)
//   ba/row/col/wdata out             : latched address/data of granted access
//   rdata in                         : read data, valid with rd_done
//   ch_req/ch_we/ch_addr/ch_wdata in : per-channel requests (packed)
//   ch_grant/ch_done out, ch_rdata out : per-channel grant, done, read data
// -----------------------------------------------------------------------------
module sdram_mc_arbiter
    import sdram_pkg::*;
#(
    parameter  int NUM_CH     = 2,
    parameter  int BA_W       = 2,
    parameter  int ROW_W      = 13,
    parameter  int COL_W      = 10,
    parameter  int DATA_W     = 32,
    parameter  int REF_CYCLES = 780,
    localparam int ADDR_W     = BA_W + ROW_W + COL_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     init_done,
    input  logic                     ref_done,
    input  logic                     wr_done,
    input  logic                     rd_done,
    output logic                     init_en,
    output logic                     ref_en,
    output logic                     wr_en,
    output logic                     rd_en,
    output logic [1:0]               sel,
    output logic [BA_W-1:0]          ba,
    output logic [ROW_W-1:0]         row,
    output logic [COL_W-1:0]         col,
    output logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W-1:0]        rdata,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_grant,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [DATA_W-1:0]        ch_rdata
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    ref_cnt_q, ref_cnt_d;
    logic                cnt_run_q, cnt_run_d;
    logic [1:0]          ref_owed_q, ref_owed_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    gidx_q, gidx_d;
    logic [1:0]          sel_q, sel_d;
    logic                init_en_q, init_en_d;
    logic                ref_en_q, ref_en_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic [NUM_CH-1:0]   ch_grant_q, ch_grant_d;
    logic [NUM_CH-1:0]   ch_done_q, ch_done_d;
    logic [DATA_W-1:0]   ch_rdata_q, ch_rdata_d;
    logic [BA_W-1:0]     ba_q, ba_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [ADDR_W-1:0]   addr_arr  [NUM_CH];
    logic [DATA_W-1:0]   wdata_arr [NUM_CH];
    logic [NUM_CH-1:0]   rr_grant;
    logic [PTR_W-1:0]    rr_idx;
    logic                rr_valid;
    logic                ref_wrap;
    logic                ref_dec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign addr_arr[gi]  = ch_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = ch_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    sdram_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_rr (
        .req_i       (ch_req),
        .last_i      (ptr_q),
        .grant_o     (rr_grant),
        .grant_idx_o (rr_idx),
        .valid_o     (rr_valid)
    );

    // Refresh interval counter: free-running once init has completed.
    assign ref_wrap   = cnt_run_q && (ref_cnt_q == CNT_W'(REF_CYCLES - 1));
    assign ref_dec    = (state_q == ST_REF) && ref_done;
    assign cnt_run_d  = cnt_run_q | ((state_q == ST_INIT) && init_done);
    assign ref_cnt_d  = !cnt_run_q ? ref_cnt_q : (ref_wrap ? '0 : ref_cnt_q + 1'b1);
    assign ref_owed_d = owed_next(ref_owed_q, ref_wrap, ref_dec);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        init_en_d  = 1'b0;
        ref_en_d   = 1'b0;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        ch_grant_d = ch_grant_q;
        ch_done_d  = '0;
        ch_rdata_d = ch_rdata_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        ba_d       = ba_q;
        row_d      = row_q;
        col_d      = col_q;
        wdata_d    = wdata_q;
        case (state_q)
            ST_INIT: begin
                sel_d = SEL_INIT;
                if (init_done) state_d   = ST_IDLE;
                else           init_en_d = 1'b1;
            end
            ST_IDLE: begin
                if (ref_owed_q != 2'd0) begin
                    state_d  = ST_REF;
                    sel_d    = SEL_REF;
                    ref_en_d = 1'b1;
                end else if (rr_valid) begin
                    ch_grant_d              = rr_grant;
                    gidx_d                  = rr_idx;
                    {ba_d, row_d, col_d}    = addr_arr[rr_idx];
                    wdata_d                 = wdata_arr[rr_idx];
                    if (ch_we[rr_idx]) begin
                        state_d = ST_WR;
                        sel_d   = SEL_WR;
                        wr_en_d = 1'b1;
                    end else begin
                        state_d = ST_RD;
                        sel_d   = SEL_RD;
                        rd_en_d = 1'b1;
                    end
                end
            end
            ST_REF: begin
                if (ref_done) state_d = ST_IDLE;
            end
            ST_WR, ST_RD: begin
                if ((state_q == ST_WR && wr_done) || (state_q == ST_RD && rd_done)) begin
                    // Grant is one-hot, so it doubles as the done pulse vector.
                    ch_done_d  = ch_grant_q;
                    ch_grant_d = '0;
                    ptr_d      = gidx_q;
                    state_d    = ST_IDLE;
                    if (state_q == ST_RD) ch_rdata_d = rdata;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            ref_cnt_q  <= '0;
            cnt_run_q  <= 1'b0;
            ref_owed_q <= 2'd0;
            ptr_q      <= PTR_W'(NUM_CH - 1);
            gidx_q     <= '0;
            sel_q      <= SEL_INIT;
            init_en_q  <= 1'b0;
            ref_en_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            ch_grant_q <= '0;
            ch_done_q  <= '0;
            ch_rdata_q <= '0;
            ba_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ref_cnt_q  <= ref_cnt_d;
            cnt_run_q  <= cnt_run_d;
            ref_owed_q <= ref_owed_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            sel_q      <= sel_d;
            init_en_q  <= init_en_d;
            ref_en_q   <= ref_en_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            ch_grant_q <= ch_grant_d;
            ch_done_q  <= ch_done_d;
            ch_rdata_q <= ch_rdata_d;
            ba_q       <= ba_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wdata_q    <= wdata_d;
        end
    end

    assign init_en  = init_en_q;
    assign ref_en   = ref_en_q;
    assign wr_en    = wr_en_q;
    assign rd_en    = rd_en_q;
    assign sel      = sel_q;
    assign ba       = ba_q;
    assign row      = row_q;
    assign col      = col_q;
    assign wdata    = wdata_q;
    assign ch_grant = ch_grant_q;
    assign ch_done  = ch_done_q;
    assign ch_rdata = ch_rdata_q;

endmodule

// File: tb/tb_sdram_mc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_mc_arbiter
// Directed self-checking bench for sdram_mc_arbiter (NUM_CH=2, REF_CYCLES=20).
// Each scenario task drives stimulus and checks its own expected values.
// -----------------------------------------------------------------------------
module tb_sdram_mc_arbiter;
    import sdram_pkg::*;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;
    localparam int REFC   = 20;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     init_done, ref_done, wr_done, rd_done;
    logic                     init_en, ref_en, wr_en, rd_en;
    logic [1:0]               sel;
    logic [1:0]               ba;
    logic [12:0]              row;
    logic [9:0]               col;
    logic [DATA_W-1:0]        wdata, rdata, ch_rdata;
    logic [NUM_CH-1:0]        ch_req, ch_we, ch_grant, ch_done;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int init_cyc = 0;

    sdram_mc_arbiter #(
        .NUM_CH(NUM_CH), .BA_W(2), .ROW_W(13), .COL_W(10),
        .DATA_W(DATA_W), .REF_CYCLES(REFC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .init_done(init_done), .ref_done(ref_done), .wr_done(wr_done), .rd_done(rd_done),
        .init_en(init_en), .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sel(sel), .ba(ba), .row(row), .col(col), .wdata(wdata), .rdata(rdata),
        .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_grant(ch_grant), .ch_done(ch_done), .ch_rdata(ch_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_inputs;
        init_done = 1'b0; ref_done = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
        rdata = '0; ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0;
    endtask

    task automatic init_seq;
        clear_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        init_cyc = cyc;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 1'b0;
        tick(); tick();
        checks++; if (sel !== 2'd0) begin failures++; $display("FAIL reset_sel: got %0d want 0", sel); end
        checks++; if ({init_en, ref_en, wr_en, rd_en} !== 4'b0) begin failures++; $display("FAIL reset_starts: got %b want 0000", {init_en, ref_en, wr_en, rd_en}); end
        checks++; if ({ch_grant, ch_done} !== 4'b0) begin failures++; $display("FAIL reset_grant_done: got %b want 0000", {ch_grant, ch_done}); end
        checks++; if ({ba, row, col, wdata, ch_rdata} !== '0) begin failures++; $display("FAIL reset_data: got nonzero want 0"); end
        checks++; if (dut.state_q !== ST_INIT || dut.ref_owed_q !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d/%0d want INIT/0", dut.state_q, dut.ref_owed_q); end
        $display("reset: outputs checked");
    endtask

    task automatic test_init_hold;
        int bad;
        bad = 0;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 50; i++) begin
            checks++;
            if (init_en !== 1'b1 || sel !== 2'd0) begin
                failures++; bad++;
                $display("FAIL init_hold cycle %0d: init_en=%b sel=%0d want 1/0", i, init_en, sel);
            end
            tick();
        end
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        checks++; if (init_en !== 1'b0) begin failures++; $display("FAIL init_release: init_en=%b want 0", init_en); end
        checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL init_idle: state=%0d want IDLE", dut.state_q); end
        checks++; if ({ref_en, wr_en, rd_en} !== 3'b0) begin failures++; $display("FAIL init_starts: got %b want 000", {ref_en, wr_en, rd_en}); end
        $display("init: held 50 cycles, %0d bad", bad);
    endtask

    task automatic test_single_write;
        init_seq();
        ch_req = 2'b01; ch_we = 2'b01;
        ch_addr[24:0]  = {2'd1, 13'd5, 10'd9};
        ch_wdata[31:0] = 32'hA5A5_0001;
        tick();
        checks++; if (wr_en !== 1'b1 || sel !== 2'd2) begin failures++; $display("FAIL wr_start: wr_en=%b sel=%0d want 1/2", wr_en, sel); end
        checks++; if (ba !== 2'd1 || row !== 13'd5 || col !== 10'd9) begin failures++; $display("FAIL wr_addr: got %0d/%0d/%0d want 1/5/9", ba, row, col); end
        checks++; if (wdata !== 32'hA5A5_0001 || ch_grant !== 2'b01) begin failures++; $display("FAIL wr_data_grant: got %h/%b want a5a50001/01", wdata, ch_grant); end
        tick();
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL wr_pulse: wr_en=%b want 0", wr_en); end
        repeat (8) tick();
        checks++; if (ba !== 2'd1 || row !== 13'd5 || col !== 10'd9 || ch_grant !== 2'b01) begin failures++; $display("FAIL wr_stable: got %0d/%0d/%0d/%b", ba, row, col, ch_grant); end
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0; ch_req = 2'b00;
        checks++; if (ch_done !== 2'b01 || ch_grant !== 2'b00) begin failures++; $display("FAIL wr_done: ch_done=%b grant=%b want 01/00", ch_done, ch_grant); end
        checks++; if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL wr_idle: state=%0d want IDLE", dut.state_q); end
        tick();
        checks++; if (ch_done !== 2'b00) begin failures++; $display("FAIL wr_done_pulse: ch_done=%b want 00", ch_done); end
        $display("single write: ch0 addr 1/5/9 done");
    endtask

    task automatic test_round_robin;
        int reads, budget;
        logic [1:0]  exp_g;
        logic [31:0] exp_rd;
        init_seq();
        ch_addr[24:0]  = {2'd0, 13'd10, 10'd1};
        ch_addr[49:25] = {2'd2, 13'd20, 10'd2};
        ch_req = 2'b11; ch_we = 2'b00;
        reads = 0; budget = 0;
        while (reads < 4 && budget < 300) begin
            tick(); budget++;
            if (ref_en) begin
                tick(); ref_done = 1'b1; tick(); ref_done = 1'b0; budget += 2;
            end else if (rd_en) begin
                exp_g  = (reads % 2 == 0) ? 2'b01 : 2'b10;
                exp_rd = 32'h100 + 32'(reads);
                checks++; if (ch_grant !== exp_g) begin failures++; $display("FAIL rr_grant %0d: got %b want %b", reads, ch_grant, exp_g); end
                checks++; if (sel !== 2'd3 || row !== ((exp_g == 2'b01) ? 13'd10 : 13'd20)) begin failures++; $display("FAIL rr_sel_row %0d: got %0d/%0d", reads, sel, row); end
                repeat (3) tick();
                rdata = exp_rd; rd_done = 1'b1;
                tick();
                rd_done = 1'b0; budget += 4;
                checks++; if (ch_done !== exp_g || ch_rdata !== exp_rd) begin failures++; $display("FAIL rr_done %0d: got %b/%h want %b/%h", reads, ch_done, ch_rdata, exp_g, exp_rd); end
                $display("rr read %0d: grant %b rdata %h", reads, exp_g, exp_rd);
                reads++;
            end
        end
        ch_req = 2'b00;
        checks++; if (reads != 4) begin failures++; $display("FAIL rr_timeout: reads=%0d want 4", reads); end
    endtask

    task automatic test_refresh_priority;
        int refs, writes_since, delay;
        init_seq();
        ch_req = 2'b01; ch_we = 2'b01;
        refs = 0; writes_since = 0;
        while (refs < 5 && (cyc - init_cyc) < 130) begin
            tick();
            if (ref_en) begin
                delay = (cyc - init_cyc) % REFC;
                checks++; if (sel !== 2'd1) begin failures++; $display("FAIL ref_sel: got %0d want 1", sel); end
                checks++; if (delay < 1 || delay > 6) begin failures++; $display("FAIL ref_delay: got %0d want 1..6", delay); end
                checks++; if (writes_since < 1) begin failures++; $display("FAIL ref_interleave: writes=%0d want >=1", writes_since); end
                $display("refresh %0d at +%0d cycles after wrap, %0d writes before", refs, delay, writes_since);
                refs++; writes_since = 0;
                tick(); ref_done = 1'b1; tick(); ref_done = 1'b0;
            end else if (wr_en) begin
                writes_since++;
                repeat (2) tick();
                wr_done = 1'b1; tick(); wr_done = 1'b0;
            end
        end
        ch_req = 2'b00;
        checks++; if (refs != 5) begin failures++; $display("FAIL ref_count: got %0d want 5", refs); end
    endtask

    task automatic test_owed_refresh;
        init_seq();
        ch_req = 2'b01; ch_we = 2'b01;
        tick();
        checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL owed_grant: wr_en=%b want 1", wr_en); end
        repeat (50) tick();
        checks++; if (dut.ref_owed_q !== 2'd2) begin failures++; $display("FAIL owed_count: got %0d want 2", dut.ref_owed_q); end
        wr_done = 1'b1; tick(); wr_done = 1'b0;
        checks++; if (ch_done !== 2'b01) begin failures++; $display("FAIL owed_wr_done: got %b want 01", ch_done); end
        tick();
        checks++; if (ref_en !== 1'b1 || sel !== 2'd1 || ch_grant !== 2'b00) begin failures++; $display("FAIL owed_ref1: ref_en=%b sel=%0d grant=%b", ref_en, sel, ch_grant); end
        tick(); ref_done = 1'b1; tick(); ref_done = 1'b0;
        checks++; if (dut.ref_owed_q !== 2'd1) begin failures++; $display("FAIL owed_after1: got %0d want 1", dut.ref_owed_q); end
        tick();
        checks++; if (ref_en !== 1'b1 || ch_grant !== 2'b00) begin failures++; $display("FAIL owed_ref2: ref_en=%b grant=%b want 1/00", ref_en, ch_grant); end
        tick(); ref_done = 1'b1; tick(); ref_done = 1'b0;
        checks++; if (dut.ref_owed_q !== 2'd0) begin failures++; $display("FAIL owed_after2: got %0d want 0", dut.ref_owed_q); end
        tick();
        checks++; if (wr_en !== 1'b1 || ch_grant !== 2'b01) begin failures++; $display("FAIL owed_next_grant: wr_en=%b grant=%b want 1/01", wr_en, ch_grant); end
        ch_req = 2'b00;
        $display("owed refresh: two refreshes then grant");
    endtask

    task automatic test_reset_mid_read;
        init_seq();
        ch_addr[49:25]  = {2'd3, 13'd77, 10'd33};
        ch_wdata[63:32] = 32'h1234_5678;
        ch_req = 2'b10; ch_we = 2'b00;
        tick();
        checks++; if (rd_en !== 1'b1 || ch_grant !== 2'b10 || sel !== 2'd3) begin failures++; $display("FAIL mid_rd_start: rd_en=%b grant=%b sel=%0d", rd_en, ch_grant, sel); end
        tick();
        rdata = 32'hDEAD_BEEF; rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        checks++; if (ch_done !== 2'b10 || ch_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mid_rd_done: got %b/%h want 10/deadbeef", ch_done, ch_rdata); end
        tick();
        checks++; if (rd_en !== 1'b1 || ba !== 2'd3 || row !== 13'd77) begin failures++; $display("FAIL mid_rd_regrant: rd_en=%b ba=%0d row=%0d", rd_en, ba, row); end
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (sel !== 2'd0 || ch_grant !== 2'b00 || {init_en, ref_en, wr_en, rd_en} !== 4'b0) begin failures++; $display("FAIL mid_rst_ctrl: sel=%0d grant=%b starts=%b", sel, ch_grant, {init_en, ref_en, wr_en, rd_en}); end
        checks++; if ({ba, row, col} !== 25'd0 || wdata !== 32'd0 || ch_rdata !== 32'd0) begin failures++; $display("FAIL mid_rst_data: ba=%0d row=%0d col=%0d wdata=%h rdata=%h", ba, row, col, wdata, ch_rdata); end
        ch_req = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (init_en !== 1'b1 || dut.state_q !== ST_INIT) begin failures++; $display("FAIL mid_rst_restart: init_en=%b state=%0d want 1/INIT", init_en, dut.state_q); end
        $display("reset mid-read: init restarted");
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_init_hold();
        test_single_write();
        test_round_robin();
        test_refresh_priority();
        test_owed_refresh();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_mc_arbiter.md
# sdram_mc_arbiter

Multi-channel front end for the SDRAM controller. Arbitrates `NUM_CH` local request ports round-robin, owns the auto-refresh interval counter, and sequences the init/refresh/write/read sub-engines through `sel` and one-cycle start pulses. It sits between user-side masters and the existing init, refresh, write and read engines, which share the SDRAM command bus.

## Interface
- `NUM_CH`, 2: number of local request channels (1..8).
- `BA_W`, 2: bank address width.
- `ROW_W`, 13: row address width.
- `COL_W`, 10: column address width.
- `DATA_W`, 32: data width.
- `REF_CYCLES`, 780: clk cycles between refresh requests.
- `ADDR_W` is derived as BA_W+ROW_W+COL_W.
- Clock and reset:
  - `clk` in, 1: the single clock.
  - `rst_n` in, 1: reset, asynchronous, active-low.
- Engine handshake:
  - `init_done`, `ref_done`, `wr_done`, `rd_done` in, 1 each: engine completion.
  - `init_en` out, 1: init engine enable.
  - `ref_en`, `wr_en`, `rd_en` out, 1 each: engine start pulses.
  - `sel` out, 2: command-bus mux select. INIT=0, REF=1, WR=2, RD=3.
- Address and data to the engines:
  - `ba` out, BA_W; `row` out, ROW_W; `col` out, COL_W: latched address of the granted access.
  - `wdata` out, DATA_W: latched write data.
  - `rdata` in, DATA_W: read data from the read engine, valid when `rd_done` is high.
- Local channels:
  - `ch_req` in, NUM_CH: per-channel request.
  - `ch_we` in, NUM_CH: 1 = write, 0 = read.
  - `ch_addr` in, NUM_CH*ADDR_W: packed addresses; channel i occupies `[i*ADDR_W +: ADDR_W]`, ordered {ba,row,col}.
  - `ch_wdata` in, NUM_CH*DATA_W: packed write data.
  - `ch_grant` out, NUM_CH: one-hot, high while that channel's access is in flight.
  - `ch_done` out, NUM_CH: one-cycle completion pulse.
  - `ch_rdata` out, DATA_W: read data of the last completed read.

## Operation
- **States:** INIT, IDLE, REF, WR, RD.
- **INIT**
  - `init_en`=1 and `sel`=INIT while `init_done`=0.
  - When `init_done`=1: `init_en`←0, the refresh counter starts, and the next state is IDLE.
- **Refresh counter**
  - Counts 0..REF_CYCLES-1 continuously after init, in every state.
  - On wrap it increments `ref_owed`, a 2-bit counter that saturates at 3, so a missed refresh is never dropped.
- **IDLE, priority order:**
  1. `ref_owed`≠0 → REF.
  2. Any `ch_req` → round-robin grant.
  3. Otherwise stay in IDLE.
- **Round-robin grant**
  - The search starts at the channel after the last granted one and wraps from NUM_CH-1 to 0. After reset the pointer makes channel 0 first.
  - On grant:
    - Latch `ch_addr`/`ch_wdata` of the winner into `ba`/`row`/`col`/`wdata`.
    - Set `ch_grant`.
    - Go to WR if `ch_we`=1, else RD.
- **REF**
  - `ref_en` pulses on the entry cycle; `sel`=REF.
  - On `ref_done`: decrement `ref_owed` and return to IDLE. A simultaneous counter wrap gives a net change of 0.
- **WR / RD**
  - `wr_en`/`rd_en` pulses on the entry cycle; `sel`=WR/RD.
  - Address and data stay stable until done.
  - On `wr_done`/`rd_done`:
    - Clear `ch_grant`.
    - Pulse `ch_done[g]`.
    - For reads, capture `rdata` into `ch_rdata`.
    - Advance the pointer to g.
    - Return to IDLE.
- **Ignored inputs:** `*_done` inputs are ignored outside their matching state. `ch_req` is ignored outside IDLE.
- **Requester rule:** hold `ch_req`, `ch_we`, `ch_addr`, `ch_wdata` until `ch_done`. A `ch_req` still high after `ch_done` is a new request.
- **Reset mid-operation:** every register returns to its reset value and INIT restarts. Engines are expected to be reset by the same `rst_n`.

## Timing
- **Reset values:**
  - `sel`=0; `init_en`, `ref_en`, `wr_en`, `rd_en`=0.
  - `ch_grant`, `ch_done`, `ch_rdata`, `ba`, `row`, `col`, `wdata`=0.
  - State=INIT; `ref_owed`=0; counter=0; pointer=NUM_CH-1.
- **First cycle after reset release:** `init_en`=1.
- **Grant latency:** `ch_req` sampled in IDLE at cycle t gives at t+1 `ch_grant`, `wr_en`/`rd_en`=1, `sel` and the address valid.
- **Completion latency:** done at cycle d gives at d+1 `ch_done`=1 (exactly one cycle) and state=IDLE. The next grant is at d+2 at the earliest.
- **Refresh latency:**
  - The counter wraps at cycle w, so `ref_owed` is updated at w+1.
  - Refresh starts in the first IDLE cycle after that, or waits for the in-flight access to complete.

## Structure
- Shared package `sdram_pkg`: sel encodings (INIT/REF/WR/RD) and FSM state encodings, used by this block and the engines.
- Sub-module `sdram_rr_arbiter`: parametrised NUM_CH one-hot round-robin grant, taking the request vector and last-grant pointer.

## Test plan
- **Init hold:** release reset, hold `init_done`=0 for 50 cycles, then pulse it → `init_en`=1 throughout the hold, then state IDLE, all starts 0.
- **Single write:** `ch_req`=01, `ch_we`=01, `ch_addr`={2'd1,13'd5,10'd9}, `ch_wdata`=32'hA5A5_0001 → next cycle `wr_en` pulse, `sel`=2, `ba`=1, `row`=5, `col`=9. `wr_done` 10 cycles later → `ch_done`=01 one cycle later.
- **Round robin:** both channels hold reads continuously, `rd_done` after 4 cycles with `rdata` incrementing → grants alternate 01,10,01,10 and `ch_rdata` matches each completion.
- **Refresh priority:** REF_CYCLES=20, channel 0 requests continuously → a REF (`ref_en` pulse, `sel`=1) is inserted between accesses within one access time of each wrap.
- **Owed refresh:** REF_CYCLES=20, hold `wr_done` low for 50 cycles → `ref_owed` reaches 2, then two back-to-back REF sequences run before the next grant.
- **Reset mid-read:** assert `rst_n`=0 during RD → all outputs take reset values immediately (async), and INIT restarts on release.
